kp_line_feeder: RTL and testbench

//  Line-granular pixel source for kp_kernel_control's data-in interface (i_data/i_valid/o_req).

---
 rtl/kp_line_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_kp_line_feeder.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kp_line_feeder.sv
// ---------------------------------------------------------------------------
// kp_line_feeder
//
// Line-granular pixel source that feeds the 3x3 kernel line buffers from an
// upstream first-word-fall-through capture FIFO. Each accepted request
// produces exactly one complete line of LINE_LENGTH pixels. The block tracks
// the pixel and line position and flags start/end of line and start/end of
// frame for the consumer.
//
// Optional feature (macro KP_FEEDER_BOTTOM_PAD_EN):
//   The block keeps a one-line RAM holding the pixels of the line currently
//   being fetched. After the last line of a frame, the next accepted request
//   replays that stored line (no FIFO pops), so the kernel sees a replicated
//   bottom border. A frame is then LINE_COUNT+1 lines long, and the frame-done
//   pulse follows the replayed line.
//   With the macro undefined there is no RAM and no replay state.
//
// Ports
//   i_clk         clock
//   i_rstn        synchronous active-low reset
//   i_fifo_data   FIFO head word, valid when i_fifo_empty is low
//   i_fifo_empty  FIFO empty flag
//   o_fifo_rd     FIFO pop strobe (combinational)
//   i_req         consumer asks for one more line (level, sampled in IDLE)
//   o_data        registered pixel to the consumer
//   o_valid       o_data qualifier, at most one pixel per cycle
//   o_sol         with o_valid: first pixel of a line
//   o_eol         with o_valid: last pixel of a line
//   o_sof         with o_valid: first pixel of line 0
//   o_frame_done  one-cycle pulse the cycle after the last pixel of a frame
//   o_busy        block is not idle
// ---------------------------------------------------------------------------
module kp_line_feeder #(
   parameter int LINE_LENGTH = 640,
   parameter int LINE_COUNT  = 480,
   parameter int DATA_WIDTH  = 8,
   parameter int HOLDOFF     = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_rd,
   input  logic                  i_req,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_sol,
   output logic                  o_eol,
   output logic                  o_sof,
   output logic                  o_frame_done,
   output logic                  o_busy
);

   // Counter widths; clamped to at least one bit so degenerate parameter
   // values still elaborate.
   localparam int PW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
   localparam int LW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
   localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

   localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_LENGTH - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(LINE_COUNT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

`ifdef KP_FEEDER_BOTTOM_PAD_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BURST  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_REPLAY = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;
`endif

   state_t          state_q;
   state_t          afterLineState;
   logic [PW-1:0]   pixCnt_q;
   logic [PW-1:0]   pixCnt_d;
   logic [LW-1:0]   lineCnt_q;
   logic [LW-1:0]   lineCnt_d;
   logic [HW-1:0]   holdCnt_q;
   logic [HW-1:0]   holdCnt_d;
   logic            eofPend_q;
   logic            popEn;
   logic            pixFirst;
   logic            pixLast;
   logic            lineFirst;
   logic            lineLast;

   // Pop whenever the burst is running and the FIFO has a word; an empty
   // FIFO simply stalls the line with no timeout.
   assign popEn     = (state_q == ST_BURST) && !i_fifo_empty;
   assign o_fifo_rd = popEn;
   assign o_busy    = (state_q != ST_IDLE);

   assign pixFirst  = (pixCnt_q == '0);
   assign pixLast   = (pixCnt_q == PIX_LAST);
   assign lineFirst = (lineCnt_q == '0);
   assign lineLast  = (lineCnt_q == LINE_LAST);

   assign pixCnt_d  = pixLast ? '0 : pixCnt_q + 1'b1;
   assign lineCnt_d = lineLast ? '0 : lineCnt_q + 1'b1;
   assign holdCnt_d = holdCnt_q + 1'b1;

   // With no holdoff configured a finished line goes straight back to IDLE.
   assign afterLineState = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;

`ifdef KP_FEEDER_BOTTOM_PAD_EN
   logic                  padPend_q;
   logic [DATA_WIDTH-1:0] lineRam [LINE_LENGTH];

   // Every popped pixel overwrites its slot, so after the last line of a
   // frame the RAM holds exactly that line, ready for the replay.
   always_ff @(posedge i_clk) begin
      if (popEn) begin
         lineRam[pixCnt_q] <= i_fifo_data;
      end
   end
`endif

   // Main control: state, counters and all registered outputs. Pixel flags
   // are derived from the counters at pop time so they travel with o_data.
   // A request is only looked at in IDLE, so a request that coincides with
   // the last pop of a line, or arrives during the holdoff, is not taken.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q      <= ST_IDLE;
         pixCnt_q     <= '0;
         lineCnt_q    <= '0;
         holdCnt_q    <= '0;
         eofPend_q    <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_sol        <= 1'b0;
         o_eol        <= 1'b0;
         o_sof        <= 1'b0;
         o_frame_done <= 1'b0;
`ifdef KP_FEEDER_BOTTOM_PAD_EN
         padPend_q    <= 1'b0;
`endif
      end else begin
         o_valid      <= 1'b0;
         o_sol        <= 1'b0;
         o_eol        <= 1'b0;
         o_sof        <= 1'b0;
         o_frame_done <= eofPend_q;
         eofPend_q    <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (i_req) begin
`ifdef KP_FEEDER_BOTTOM_PAD_EN
                  state_q <= padPend_q ? ST_REPLAY : ST_BURST;
`else
                  state_q <= ST_BURST;
`endif
               end
            end

            ST_BURST: begin
               if (popEn) begin
                  o_data   <= i_fifo_data;
                  o_valid  <= 1'b1;
                  o_sol    <= pixFirst;
                  o_eol    <= pixLast;
                  o_sof    <= pixFirst && lineFirst;
                  pixCnt_q <= pixCnt_d;
                  if (pixLast) begin
                     lineCnt_q <= lineCnt_d;
                     holdCnt_q <= '0;
                     state_q   <= afterLineState;
`ifdef KP_FEEDER_BOTTOM_PAD_EN
                     if (lineLast) begin
                        padPend_q <= 1'b1;
                     end
`else
                     eofPend_q <= lineLast;
`endif
                  end
               end
            end

            ST_HOLD: begin
               if (holdCnt_q == HOLD_LAST) begin
                  holdCnt_q <= '0;
                  state_q   <= ST_IDLE;
               end else begin
                  holdCnt_q <= holdCnt_d;
               end
            end

`ifdef KP_FEEDER_BOTTOM_PAD_EN
            // Replay never touches the FIFO and never stalls.
            ST_REPLAY: begin
               o_data   <= lineRam[pixCnt_q];
               o_valid  <= 1'b1;
               o_sol    <= pixFirst;
               o_eol    <= pixLast;
               pixCnt_q <= pixCnt_d;
               if (pixLast) begin
                  lineCnt_q <= '0;
                  holdCnt_q <= '0;
                  padPend_q <= 1'b0;
                  eofPend_q <= 1'b1;
                  state_q   <= afterLineState;
               end
            end
`endif

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kp_line_feeder.sv
// ---------------------------------------------------------------------------
// tb_kp_line_feeder
//
// Self-checking bench for kp_line_feeder with LINE_LENGTH=8, LINE_COUNT=4,
// HOLDOFF=3. A FIFO model preloaded with a byte ramp feeds the design. The
// reference model predicts the pixel stream from the line/frame rules: the
// FIFO words in pop order, grouped into lines, with start/end flags and the
// frame-done pulse after the last line of each frame (after the replayed
// line when KP_FEEDER_BOTTOM_PAD_EN is defined).
// ---------------------------------------------------------------------------
module tb_kp_line_feeder;

   localparam int LL    = 8;
   localparam int LC    = 4;
   localparam int HO    = 3;
   localparam int DW    = 8;
   localparam int STALL = 5;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] fifoData;
   logic          fifoEmpty;
   logic          fifoRd;
   logic          req;
   logic [DW-1:0] data;
   logic          valid;
   logic          sol;
   logic          eol;
   logic          sof;
   logic          frameDone;
   logic          busy;

   // FIFO model: ramp memory with read/write pointers and a forced-empty control.
   logic [7:0]    mem [1024];
   int            rdPtr = 0;
   int            wrPtr = 0;
   logic          forceEmpty;
   logic          fifoClr;

   int            checks = 0;
   int            passes = 0;
   logic          fdDue;

   // Reference model state.
   int            mPix;
   int            mLine;
   int            mExp;
   bit            mReplay;
   logic [7:0]    curLine [LL];
   logic [7:0]    lastLine [LL];

   always #5 clk = ~clk;

   assign fifoEmpty = forceEmpty || (rdPtr >= wrPtr);
   assign fifoData  = mem[rdPtr % 1024];

   always @(posedge clk) begin
      if (fifoClr) begin
         rdPtr <= 0;
      end else if (fifoRd) begin
         rdPtr <= rdPtr + 1;
      end
   end

   kp_line_feeder #(
      .LINE_LENGTH (LL),
      .LINE_COUNT  (LC),
      .DATA_WIDTH  (DW),
      .HOLDOFF     (HO)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_fifo_data  (fifoData),
      .i_fifo_empty (fifoEmpty),
      .o_fifo_rd    (fifoRd),
      .i_req        (req),
      .o_data       (data),
      .o_valid      (valid),
      .o_sol        (sol),
      .o_eol        (eol),
      .o_sof        (sof),
      .o_frame_done (frameDone),
      .o_busy       (busy)
   );

   // Restart the reference model at a frame boundary, aligned to the FIFO head.
   task automatic modelReset();
      mPix    = 0;
      mLine   = 0;
      mExp    = rdPtr;
      mReplay = 0;
      fdDue   = 1'b0;
   endtask

   // Produce the next expected pixel of the stream and advance the model.
   task automatic expectNext(output logic [7:0] d, output logic s, output logic e,
                             output logic f, output logic fd);
      s = (mPix == 0);
      e = (mPix == LL - 1);
      if (mReplay) begin
         d  = lastLine[mPix];
         f  = 1'b0;
         fd = e;
      end else begin
         d = mem[mExp % 1024];
         mExp++;
         curLine[mPix] = d;
         f = s && (mLine == 0);
`ifdef KP_FEEDER_BOTTOM_PAD_EN
         fd = 1'b0;
`else
         fd = e && (mLine == LC - 1);
`endif
      end
      if (e) begin
         mPix = 0;
         if (mReplay) begin
            mReplay = 0;
            mLine   = 0;
         end else if (mLine == LC - 1) begin
            mLine = 0;
`ifdef KP_FEEDER_BOTTOM_PAD_EN
            mReplay  = 1;
            lastLine = curLine;
`endif
         end else begin
            mLine++;
         end
      end else begin
         mPix++;
      end
   endtask

   // Reset both the design and the FIFO model; no checking here.
   task automatic applyStimulus(input int words);
      rstn       = 1'b0;
      fifoClr    = 1'b1;
      req        = 1'b0;
      forceEmpty = 1'b0;
      repeat (2) @(negedge clk);
      rstn    = 1'b1;
      fifoClr = 1'b0;
      wrPtr   = words;
      modelReset();
   endtask

   task automatic test_reset();
      rstn       = 1'b0;
      fifoClr    = 1'b1;
      req        = 1'b0;
      forceEmpty = 1'b0;
      wrPtr      = 64;
      repeat (3) @(negedge clk);
      checks++;
      if ({valid, sol, eol, sof, frameDone, busy, data} !== '0)
         $display("[TB] FAIL reset_outputs got=%b%b%b%b%b%b data=%h exp=all zero",
                  valid, sol, eol, sof, frameDone, busy, data);
      else passes++;
      rstn    = 1'b1;
      fifoClr = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({valid, fifoRd, busy, frameDone} !== 4'b0000)
            $display("[TB] FAIL idle_no_req cyc=%0d got valid/rd/busy/fd=%b%b%b%b exp=0000",
                     c, valid, fifoRd, busy, frameDone);
         else passes++;
      end
      checks++;
      if (rdPtr !== 0) $display("[TB] FAIL idle_no_pop got=%0d exp=0", rdPtr);
      else passes++;
   endtask

   task automatic test_single_line();
      logic [7:0] eD;
      logic eS, eE, eF, eFd;
      int nPix = 0;
      int first = -1;
      int last = -1;
      applyStimulus(64);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         checks++;
         if (frameDone !== fdDue) $display("[TB] FAIL single_fd cyc=%0d got=%b exp=%b", c, frameDone, fdDue);
         else passes++;
         fdDue = 1'b0;
         if (valid === 1'b1) begin
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL single_px n=%0d got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        nPix, data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
            fdDue = eFd;
            if (first < 0) first = c;
            last = c;
            nPix++;
         end
      end
      checks++;
      if (nPix !== LL || last - first !== LL - 1)
         $display("[TB] FAIL single_contig got n=%0d span=%0d exp n=%0d span=%0d", nPix, last - first, LL, LL - 1);
      else passes++;
      checks++;
      if (rdPtr !== LL) $display("[TB] FAIL single_pops got=%0d exp=%0d", rdPtr, LL);
      else passes++;
   endtask

   task automatic test_frame();
      logic [7:0] eD;
      logic eS, eE, eF, eFd;
      int nPix = 0;
      int lastEol = -1;
      int c = 0;
      applyStimulus((LC + 1) * LL);
      req = 1'b1;
      while (c < 400 && nPix < (LC + 1) * LL) begin
         @(negedge clk);
         checks++;
         if (frameDone !== fdDue) $display("[TB] FAIL frame_fd cyc=%0d got=%b exp=%b", c, frameDone, fdDue);
         else passes++;
         fdDue = 1'b0;
         if (valid === 1'b1) begin
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL frame_px n=%0d got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        nPix, data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
            // With the request held, each line follows the previous end of
            // line after the holdoff, the idle sample and the output register.
            if (eS && lastEol >= 0) begin
               checks++;
               if (c - lastEol !== HO + 2)
                  $display("[TB] FAIL frame_holdoff got=%0d exp=%0d", c - lastEol, HO + 2);
               else passes++;
            end
            if (eE) lastEol = c;
            fdDue = eFd;
            nPix++;
         end
         c++;
      end
      req = 1'b0;
      checks++;
      if (nPix !== (LC + 1) * LL) $display("[TB] FAIL frame_count got=%0d exp=%0d", nPix, (LC + 1) * LL);
      else passes++;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if ({valid, frameDone} !== {1'b0, fdDue})
            $display("[TB] FAIL frame_tail cyc=%0d got valid/fd=%b%b exp=0%b", k, valid, frameDone, fdDue);
         else passes++;
         fdDue = 1'b0;
      end
      checks++;
      if (rdPtr !== mExp) $display("[TB] FAIL frame_pops got=%0d exp=%0d", rdPtr, mExp);
      else passes++;
   endtask

   task automatic test_stall();
      logic [7:0] eD;
      logic eS, eE, eF, eFd;
      int nPix = 0;
      int pxCyc [LL];
      int stallLeft = 0;
      bit started = 0;
      applyStimulus(4);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         checks++;
         if (frameDone !== fdDue) $display("[TB] FAIL stall_fd cyc=%0d got=%b exp=%b", c, frameDone, fdDue);
         else passes++;
         fdDue = 1'b0;
         if (valid === 1'b1) begin
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL stall_px n=%0d got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        nPix, data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
            fdDue = eFd;
            if (nPix < LL) pxCyc[nPix] = c;
            nPix++;
         end
         if (!started && rdPtr == 4) begin
            started   = 1;
            stallLeft = STALL;
         end else if (stallLeft > 0) begin
            stallLeft--;
            if (stallLeft == 0) wrPtr = LL;
         end
      end
      checks++;
      if (nPix !== LL) $display("[TB] FAIL stall_count got=%0d exp=%0d", nPix, LL);
      else passes++;
      if (nPix == LL) begin
         checks++;
         if (pxCyc[4] - pxCyc[3] !== STALL + 1 || pxCyc[3] - pxCyc[0] !== 3 || pxCyc[7] - pxCyc[4] !== 3)
            $display("[TB] FAIL stall_gap got=%0d/%0d/%0d exp=%0d/3/3",
                     pxCyc[4] - pxCyc[3], pxCyc[3] - pxCyc[0], pxCyc[7] - pxCyc[4], STALL + 1);
         else passes++;
      end
   endtask

   task automatic test_reset_midburst();
      logic [7:0] eD;
      logic eS, eE, eF, eFd;
      int nPix = 0;
      bit hit = 0;
      bit sawSof = 0;
      int c = 0;
      applyStimulus(200);
      req = 1'b1;
      while (c < 200 && !hit) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            hit = (mLine == 2) && (mPix == 5) && !mReplay;
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL rst_pre_px got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
         end
         c++;
      end
      checks++;
      if (!hit) $display("[TB] FAIL rst_reach_px5 got=0 exp=1");
      else passes++;
      rstn = 1'b0;
      req  = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid, sol, eol, sof, frameDone, busy, fifoRd, data} !== '0)
         $display("[TB] FAIL rst_mid_outputs got=%b%b%b%b%b%b%b data=%h exp=all zero",
                  valid, sol, eol, sof, frameDone, busy, fifoRd, data);
      else passes++;
      rstn = 1'b1;
      modelReset();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            if (nPix == 0) sawSof = sof;
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL rst_post_px n=%0d got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        nPix, data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
            nPix++;
         end
      end
      checks++;
      if (nPix !== LL || sawSof !== 1'b1)
         $display("[TB] FAIL rst_post_line got n=%0d sof=%b exp n=%0d sof=1", nPix, sawSof, LL);
      else passes++;
   endtask

   task automatic test_random();
      logic [7:0] eD;
      logic eS, eE, eF, eFd;
      int nPix = 0;
      applyStimulus(1000);
      for (int c = 0; c < 660; c++) begin
         @(negedge clk);
         checks++;
         if (frameDone !== fdDue) $display("[TB] FAIL rand_fd cyc=%0d got=%b exp=%b", c, frameDone, fdDue);
         else passes++;
         fdDue = 1'b0;
         if (valid === 1'b1) begin
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL rand_px n=%0d got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        nPix, data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
            fdDue = eFd;
            nPix++;
         end
         // Random traffic for most of the window, then a quiet drain.
         if (c < 600) begin
            forceEmpty = ($urandom_range(0, 3) == 0);
            req        = ($urandom_range(0, 2) == 0);
         end else begin
            forceEmpty = 1'b0;
            req        = 1'b0;
         end
      end
      checks++;
      if (busy !== 1'b0 || mPix !== 0 || rdPtr !== mExp || nPix < 4 * LL)
         $display("[TB] FAIL rand_end got busy=%b mPix=%0d pops=%0d px=%0d exp busy=0 mPix=0 pops=%0d px>=%0d",
                  busy, mPix, rdPtr, nPix, mExp, 4 * LL);
      else passes++;
   endtask

`ifdef KP_FEEDER_BOTTOM_PAD_EN
   task automatic test_bottom_pad();
      logic [7:0] eD;
      logic eS, eE, eF, eFd;
      int nPix = 0;
      int nFd = 0;
      int c = 0;
      applyStimulus(64);
      req = 1'b1;
      while (c < 400 && nPix < (LC + 1) * LL) begin
         @(negedge clk);
         if (frameDone === 1'b1) nFd++;
         checks++;
         if (mReplay && fifoRd !== 1'b0) $display("[TB] FAIL pad_no_pop cyc=%0d got=%b exp=0", c, fifoRd);
         else passes++;
         if (valid === 1'b1) begin
            expectNext(eD, eS, eE, eF, eFd);
            checks++;
            if ({data, sol, eol, sof} !== {eD, eS, eE, eF})
               $display("[TB] FAIL pad_px n=%0d got=%h sol/eol/sof=%b%b%b exp=%h %b%b%b",
                        nPix, data, sol, eol, sof, eD, eS, eE, eF);
            else passes++;
            nPix++;
         end
         c++;
      end
      req = 1'b0;
      @(negedge clk);
      checks++;
      if (frameDone !== 1'b1 || nFd !== 0)
         $display("[TB] FAIL pad_fd got=%b early=%0d exp=1 early=0", frameDone, nFd);
      else passes++;
      checks++;
      if (rdPtr !== LC * LL) $display("[TB] FAIL pad_pops got=%0d exp=%0d", rdPtr, LC * LL);
      else passes++;
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      rstn       = 1'b0;
      req        = 1'b0;
      forceEmpty = 1'b0;
      fifoClr    = 1'b1;
      fdDue      = 1'b0;
      test_reset();
      test_single_line();
      test_frame();
      test_stall();
      test_reset_midburst();
      test_random();
`ifdef KP_FEEDER_BOTTOM_PAD_EN
      test_bottom_pad();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
